sb_drain: RTL and testbench
===========================

SB_DRAIN -- requirements
Module: sb_drain

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, memory byte-address width; MERGE_MAX, default 4, maximum entries combined into one write; CNT_WIDTH, default 16, drain-counter width.
REQ-002 The block SHALL run on one clock and use an asynchronous, active-low reset; ports are clk and rst_n, clock and reset first.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sb_entry_receiver  handshake_if.receiver  sb_entry_t  committed store entries (addr, data, strb)
- mem_req_valid  out  1  write request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits zero
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes
- mem_resp_valid  in  1  write completion
- mem_resp_err  in  1  completion error, qualified by mem_resp_valid
- busy_o  out  1  entry held or write in flight
- err_o  out  1  sticky write error
- drain_cnt_o  out  CNT_WIDTH  completed writes, wrapping

Function
REQ-004 The FSM SHALL have states IDLE, HOLD, REQ and WAIT.
REQ-005 sb_entry_receiver.ready SHALL be 1 in IDLE and 0 in REQ and WAIT.
REQ-006 In IDLE, an accepted entry SHALL be latched into the pending register (word address = addr[ADDR_WIDTH-1:2], data, strb).
- Next state SHALL be HOLD if SB_DRAIN_MERGE_EN is defined, otherwise REQ.
REQ-007 In REQ, mem_req_valid SHALL be 1.
- mem_addr, mem_wdata and mem_wstrb SHALL stay stable until mem_req_ready is sampled high.
- On mem_req_valid & mem_req_ready the FSM SHALL go to WAIT.
REQ-008 In WAIT, on mem_resp_valid the FSM SHALL go to IDLE and drain_cnt_o SHALL increment by 1, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-009 Latency without merging SHALL be: entry accepted in cycle N; mem_req_valid high in cycle N+1.
REQ-010 mem_resp_valid outside WAIT SHALL be ignored: no counter change, no error.
REQ-011 mem_resp_valid & mem_resp_err SHALL set err_o.
- err_o SHALL stay set until reset.
- The FSM SHALL return to IDLE regardless; there is no retry.
REQ-012 busy_o SHALL be 1 in every state except IDLE.
REQ-013 The block SHALL have no flush input; committed stores are never discarded.

Reset
REQ-014 While rst_n is low, regardless of clock, the block SHALL hold: state IDLE, pending register 0, mem_req_valid 0, err_o 0, drain_cnt_o 0, busy_o 0.
REQ-015 Reset asserted in REQ or WAIT SHALL abandon the write with no completion counted.
REQ-016 After rst_n deasserts, the first entry SHALL be accepted in the first clock edge with rst_n high.

Configuration
REQ-017 The merge feature SHALL be controlled by macro SB_DRAIN_MERGE_EN.
REQ-018 With SB_DRAIN_MERGE_EN defined:
- In HOLD, ready SHALL be 1 only when the incoming valid entry's word address equals the pending word address and the merge count is below MERGE_MAX.
- Each merge SHALL overwrite byte i of the pending data when incoming strb[i]=1.
- Each merge SHALL OR the incoming strb into the pending strb and increment the merge count.
- HOLD SHALL go to REQ in the first cycle with no merge.
- The merge count SHALL reset to 1 on IDLE acceptance.
- drain_cnt_o SHALL count memory writes, not entries.
REQ-019 Without SB_DRAIN_MERGE_EN, HOLD SHALL be unreachable and every entry SHALL produce exactly one write.

Structure
REQ-020 sb_entry_t and the FSM state enum SHALL live in the shared package included via a_defines.svh.
REQ-021 Byte-merge logic SHALL be sub-module sb_drain_merge (pending data/strb plus incoming data/strb in, merged data/strb out), instantiated only under SB_DRAIN_MERGE_EN.
REQ-022 All other logic SHALL be flat in sb_drain.

Verification
REQ-023 Single store: addr 0x1004, data 0xAABBCCDD, strb 0xF, mem_req_ready tied 1 -> mem_req_valid in cycle N+1 (N+2 with merge), mem_addr 0x1004; after response drain_cnt_o = 1.
REQ-024 Backpressure: mem_req_ready low for 5 cycles -> mem_addr, mem_wdata, mem_wstrb and mem_req_valid stable throughout; receiver.ready = 0 throughout.
REQ-025 Merge (macro on): back-to-back entries to 0x2000 (strb 0x1, data 0x11) and 0x2001 (strb 0x2, data 0x2200) -> one write, mem_wstrb 0x3, mem_wdata[15:0] = 0x2211; drain_cnt_o = 1.
REQ-026 Merge limit (macro on): 6 back-to-back same-word entries, MERGE_MAX=4 -> two writes of 4 and 2 entries; no entry lost.
REQ-027 Error and reset: response with mem_resp_err = 1 -> err_o = 1 and held; rst_n pulsed low mid-WAIT -> all outputs 0 immediately, before the next clock edge.
REQ-028 Counter wrap: CNT_WIDTH=4, 17 writes -> drain_cnt_o = 1.

Source files
------------

// File: rtl/sb_drain_pkg.sv
// Shared types for the store-buffer drain: committed-entry record and drain FSM states.
package sb_drain_pkg;

  localparam int SB_ADDR_MAX = 32;
  localparam int SB_DATA_W   = 32;
  localparam int SB_STRB_W   = SB_DATA_W / 8;

  typedef struct packed {
    logic [SB_ADDR_MAX-1:0] addr;
    logic [SB_DATA_W-1:0]   data;
    logic [SB_STRB_W-1:0]   strb;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REQ,
    WAIT
  } sb_state_e;

endpackage

// File: rtl/handshake_if.sv
// Valid/ready channel carrying one committed store entry per transfer.
interface handshake_if;
  import sb_drain_pkg::*;

  logic      valid;
  logic      ready;
  sb_entry_t data;

  modport sender   (output valid, output data, input ready);
  modport receiver (input valid, input data, output ready);
endinterface

// File: rtl/sb_drain_merge.sv
// Byte-lane merge of an incoming store into the pending write word.
module sb_drain_merge
  import sb_drain_pkg::*;
(
  input  logic [SB_DATA_W-1:0] i_pend_data,
  input  logic [SB_STRB_W-1:0] i_pend_strb,
  input  logic [SB_DATA_W-1:0] i_in_data,
  input  logic [SB_STRB_W-1:0] i_in_strb,
  output logic [SB_DATA_W-1:0] o_data,
  output logic [SB_STRB_W-1:0] o_strb
);

  // NOTE: o_data gets a full default before the per-byte overrides, so no latch is inferred.
  always_comb begin
    o_data = i_pend_data;
    for (int i = 0; i < SB_STRB_W; i++) begin
      if (i_in_strb[i]) o_data[8*i +: 8] = i_in_data[8*i +: 8];
    end
  end

  assign o_strb = i_pend_strb | i_in_strb;

endmodule

// File: rtl/sb_drain.sv
// Store-buffer drain: one committed entry at a time becomes one memory write.
// Macro SB_DRAIN_MERGE_EN adds a HOLD state that merges same-word entries into that write.
module sb_drain
  import sb_drain_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MERGE_MAX  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  handshake_if.receiver         sb_entry_receiver,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [SB_DATA_W-1:0]  mem_wdata,
  output logic [SB_STRB_W-1:0]  mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic                  mem_resp_err,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  drain_cnt_o
);

  localparam int WA_W = ADDR_WIDTH - 2;

  sb_state_e              r_state;
  sb_state_e              w_next;
  logic [WA_W-1:0]        r_waddr;
  logic [SB_DATA_W-1:0]   r_data;
  logic [SB_STRB_W-1:0]   r_strb;
  logic                   r_err;
  logic [CNT_WIDTH-1:0]   r_cnt;

  logic                   w_ready;
  logic                   w_load;
  logic                   w_merge;
  logic                   w_done;
  logic [WA_W-1:0]        w_in_waddr;
  logic                   w_unused_addr_lo;

  // Entries are byte addressed; the write channel only sees word addresses.
  assign w_in_waddr       = sb_entry_receiver.data.addr[ADDR_WIDTH-1:2];
  assign w_unused_addr_lo = ^sb_entry_receiver.data.addr[1:0];

`ifdef SB_DRAIN_MERGE_EN
  localparam int MC_W = $clog2(MERGE_MAX + 1);

  logic [MC_W-1:0]      r_mcnt;
  logic [SB_DATA_W-1:0] w_mrg_data;
  logic [SB_STRB_W-1:0] w_mrg_strb;

  sb_drain_merge u_merge (
    .i_pend_data (r_data),
    .i_pend_strb (r_strb),
    .i_in_data   (sb_entry_receiver.data.data),
    .i_in_strb   (sb_entry_receiver.data.strb),
    .o_data      (w_mrg_data),
    .o_strb      (w_mrg_strb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcnt <= '0;
    end else if (w_load) begin
      r_mcnt <= MC_W'(1);
    end else if (w_merge) begin
      r_mcnt <= r_mcnt + MC_W'(1);
    end
  end
`else
  localparam int MERGE_MAX_UNUSED = MERGE_MAX;
`endif

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_load  = 1'b0;
    w_merge = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (sb_entry_receiver.valid) begin
          w_load = 1'b1;
`ifdef SB_DRAIN_MERGE_EN
          w_next = HOLD;
`else
          w_next = REQ;
`endif
        end
      end
      HOLD: begin
        // Any cycle without a merge closes the word and issues the write.
        w_next = REQ;
`ifdef SB_DRAIN_MERGE_EN
        if (sb_entry_receiver.valid && (w_in_waddr == r_waddr) &&
            (r_mcnt < MC_W'(MERGE_MAX))) begin
          w_ready = 1'b1;
          w_merge = 1'b1;
          w_next  = HOLD;
        end
`endif
      end
      REQ: begin
        if (mem_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the pending word is reset as well, so the write outputs read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_waddr <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_waddr <= w_in_waddr;
        r_data  <= sb_entry_receiver.data.data;
        r_strb  <= sb_entry_receiver.data.strb;
      end
`ifdef SB_DRAIN_MERGE_EN
      if (w_merge) begin
        r_data <= w_mrg_data;
        r_strb <= w_mrg_strb;
      end
`endif
      if (w_done) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
        if (mem_resp_err) r_err <= 1'b1;
      end
    end
  end

  assign sb_entry_receiver.ready = w_ready;
  assign mem_req_valid           = (r_state == REQ);
  assign mem_addr                = {r_waddr, 2'b00};
  assign mem_wdata               = r_data;
  assign mem_wstrb               = r_strb;
  assign busy_o                  = (r_state != IDLE);
  assign err_o                   = r_err;
  assign drain_cnt_o             = r_cnt;

endmodule

// File: tb/tb_sb_drain.sv
// Self-checking bench for sb_drain: vector table plus scoreboard of expected memory writes.
module tb_sb_drain;
  import sb_drain_pkg::*;

  localparam int AW = 32;
  localparam int CW = 4;
  localparam int MM = 4;
`ifdef SB_DRAIN_MERGE_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_resp_valid;
  logic          mem_resp_err;
  logic          busy_o;
  logic          err_o;
  logic [CW-1:0] drain_cnt_o;

  handshake_if hs ();

  sb_drain #(.ADDR_WIDTH(AW), .MERGE_MAX(MM), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sb_entry_receiver (hs),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_err      (mem_resp_err),
    .busy_o            (busy_o),
    .err_o             (err_o),
    .drain_cnt_o       (drain_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          stall;
    bit          err;
    logic [31:0] exp_addr;
  } vec_t;

  wr_t           sb_q[$];
  vec_t          vecs[6];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] exp_cnt;
  logic          exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one entry starting at posedge+1; returns how many edges it took to be accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int edges);
    bit taken = 0;
    hs.data  = '{addr: a, data: d, strb: s};
    hs.valid = 1'b1;
    edges    = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      edges++;
      if (hs.ready) begin
        taken = 1;
        break;
      end
    end
    check("send_accepted", 64'(taken), 64'(1));
    @(posedge clk);
    #1;
    hs.valid = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (!mem_req_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("req_seen", 64'(mem_req_valid), 64'(1));
  endtask

  // Called in REQ at posedge+1: compares against the scoreboard, stalls, completes.
  task automatic do_write(input int stall, input bit err);
    wr_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: write seen with no expected entry at %0t", $time);
      return;
    end
    e = sb_q.pop_front();
    check("wr_addr", 64'(mem_addr), 64'(e.addr));
    check("wr_data", 64'(mem_wdata), 64'(e.data));
    check("wr_strb", 64'(mem_wstrb), 64'(e.strb));
    mem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_stable", {mem_req_valid, mem_addr, mem_wdata[26:0], mem_wstrb},
            {1'b1, e.addr, e.data[26:0], e.strb});
      check("stall_rx_ready", 64'(hs.ready), 64'(0));
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    check("wait_busy", 64'({busy_o, mem_req_valid, hs.ready}), 64'(3'b100));
    mem_resp_valid = 1'b1;
    mem_resp_err   = err;
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    exp_err = exp_err | err;
    check("drain_cnt", 64'(drain_cnt_o), 64'(exp_cnt));
    check("err_o", 64'(err_o), 64'(exp_err));
    check("idle_busy", 64'(busy_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int lat;
    vecs[0] = '{32'h0000_1004, 32'hAABB_CCDD, 4'hF, 0, 1'b0, 32'h0000_1004};
    vecs[1] = '{32'h0000_2003, 32'h1234_5678, 4'h1, 5, 1'b0, 32'h0000_2000};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 4'h8, 1, 1'b0, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_0000, 32'h5A5A_5A5A, 4'h6, 0, 1'b0, 32'h0000_0000};
    vecs[4] = '{32'h8000_0002, 32'hCAFE_F00D, 4'hC, 2, 1'b1, 32'h8000_0000};
    vecs[5] = '{32'h0000_1234, 32'h00FF_00FF, 4'h5, 0, 1'b0, 32'h0000_1234};

    hs.valid       = 1'b0;
    hs.data        = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    exp_cnt        = '0;
    exp_err        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {mem_req_valid, busy_o, err_o, drain_cnt_o, mem_addr, mem_wstrb},
          '0);
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    rst_n = 1'b1;

    // A completion while IDLE must change nothing.
    mem_resp_valid = 1'b1;
    mem_resp_err   = 1'b1;
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    check("stray_resp", 64'({busy_o, err_o, drain_cnt_o}), 64'(0));

    foreach (vecs[i]) begin
      sb_q.push_back('{vecs[i].exp_addr, vecs[i].data, vecs[i].strb});
      send(vecs[i].addr, vecs[i].data, vecs[i].strb, edges);
      check("accept_edges", 64'(edges), 64'(1));
      wait_req(lat);
      check("req_latency", 64'(lat), 64'(EXP_LAT));
      do_write(vecs[i].stall, vecs[i].err);
    end

    for (int i = 0; i < 11; i++) begin
      logic [31:0] d;
      d = $urandom;
      sb_q.push_back('{32'h4000 + 32'(i * 4), d, 4'hF});
      send(32'h4000 + 32'(i * 4), d, 4'hF, edges);
      wait_req(lat);
      do_write(0, 1'b0);
    end
    check("wrap_17_writes", 64'(drain_cnt_o), 64'(1));

`ifdef SB_DRAIN_MERGE_EN
    sb_q.push_back('{32'h2000, 32'h0000_2211, 4'h3});
    send(32'h2000, 32'h0000_0011, 4'h1, edges);
    send(32'h2001, 32'h0000_2200, 4'h2, edges);
    check("merge_accept", 64'(edges), 64'(1));
    wait_req(lat);
    check("merge_latency", 64'(lat), 64'(1));
    do_write(0, 1'b0);

    sb_q.push_back('{32'h3000, 32'h0403_0201, 4'hF});
    sb_q.push_back('{32'h3000, 32'h0000_0605, 4'h3});
    for (int i = 0; i < 4; i++) begin
      send(32'h3000, 32'(i + 1) << (8 * i), 4'(1 << i), edges);
      check("limit_accept", 64'(edges), 64'(1));
    end
    fork
      begin
        int e2;
        send(32'h3000, 32'h0000_0005, 4'h1, e2);
        send(32'h3000, 32'h0000_0600, 4'h2, e2);
      end
    join_none
    wait_req(lat);
    do_write(0, 1'b0);
    wait_req(lat);
    do_write(0, 1'b0);
    wait fork;
    check("limit_sb_drained", 64'(sb_q.size()), 64'(0));
`endif

    // Reset in the middle of WAIT abandons the write.
    sb_q.push_back('{32'h5550, 32'h1357_9BDF, 4'hF});
    send(32'h5550, 32'h1357_9BDF, 4'hF, edges);
    wait_req(lat);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    check("pre_rst_wait", 64'({busy_o, mem_req_valid}), 64'(2'b10));
    void'(sb_q.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({mem_req_valid, busy_o, err_o, drain_cnt_o}), 64'(0));
    check("async_rst_data", {mem_addr, mem_wdata}, 64'(0));
    check("async_rst_strb", 64'(mem_wstrb), 64'(0));
    exp_cnt = '0;
    exp_err = 1'b0;

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    sb_q.push_back('{32'h6664, 32'h0BAD_CAFE, 4'h9});
    send(32'h6667, 32'h0BAD_CAFE, 4'h9, edges);
    check("first_edge_accept", 64'(edges), 64'(1));
    wait_req(lat);
    do_write(0, 1'b0);
    check("post_rst_cnt", 64'(drain_cnt_o), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
